// File: rtl/bcd_mult11_gen.sv
// 4-digit BCD source stepping by 11 on a valid/ready stream; its D feeds the
// BCD divisible-by-11 checker. Optional count-down via BCD_MULT11_GEN_DOWN_EN (adds dir).
module bcd_mult11_gen #(
  parameter logic [15:0] START = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        ready,
`ifdef BCD_MULT11_GEN_DOWN_EN
  input  logic        dir,
`endif
  output logic [15:0] D,
  output logic        valid,
  output logic        wrap,
  output logic        err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [15:0] d_nxt, step_word;
  logic        wrap_nxt, err_nxt, step_wrap, hs;

  // Decimal add: bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i+:4] = s[3:0];
    end
    return {c, r};
  endfunction

`ifdef BCD_MULT11_GEN_DOWN_EN
  // Decimal subtract: bit 16 is the borrow out of the thousands digit.
  function automatic logic [16:0] bcd_sub(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic        bw;
    logic [15:0] r;
    bw = 1'b0;
    r  = '0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i+:4]} - {1'b0, b[4*i+:4]} - {4'b0, bw};
      if (s[4]) begin
        s  = s + 5'd10;
        bw = 1'b1;
      end else begin
        bw = 1'b0;
      end
      r[4*i+:4] = s[3:0];
    end
    return {bw, r};
  endfunction
`endif

  function automatic logic bcd_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (v[4*i+:4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  assign valid = (state == RUN);
  assign hs    = valid && ready;

  always_comb begin
    logic [16:0] up;
`ifdef BCD_MULT11_GEN_DOWN_EN
    logic [16:0] dn;
`endif
    up        = bcd_add(D, 16'h0011);
    step_word = up[16] ? 16'h0000 : up[15:0];
    step_wrap = up[16];
`ifdef BCD_MULT11_GEN_DOWN_EN
    dn = bcd_sub(D, 16'h0011);
    if (dir) begin
      step_word = dn[16] ? 16'h9999 : dn[15:0];
      step_wrap = dn[16];
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    d_nxt     = D;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          if (bcd_ok(load_val)) d_nxt = load_val;
          else                  err_nxt = 1'b1;
        end else if (en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // The offered word holds until accepted; en is only honoured at acceptance.
        if (hs) begin
          d_nxt    = step_word;
          wrap_nxt = step_wrap;
          if (!en) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      D     <= START;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      D     <= d_nxt;
      wrap  <= wrap_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_mult11_gen.sv
// Bench for bcd_mult11_gen: integer-domain reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_bcd_mult11_gen;
  localparam logic [15:0] START = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, load = 1'b0, ready = 1'b0;
  logic [15:0] load_val = 16'h0000;
`ifdef BCD_MULT11_GEN_DOWN_EN
  logic        dir = 1'b0;
`endif
  logic [15:0] D;
  logic        valid, wrap, err;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_mult11_gen #(.START(START)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val), .ready(ready),
`ifdef BCD_MULT11_GEN_DOWN_EN
    .dir(dir),
`endif
    .D(D), .valid(valid), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] v);
    return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic bit is_bcd(input logic [15:0] v);
    return (v[15:12] <= 9) && (v[11:8] <= 9) && (v[7:4] <= 9) && (v[3:0] <= 9);
  endfunction

  // Reference step in plain decimal arithmetic: out of range wraps to the far end.
  function automatic int next_val(input int v, input bit down);
    if (down) return (v < 11) ? 9999 : v - 11;
    return (v > 9988) ? 0 : v + 11;
  endfunction

  function automatic bit next_wraps(input int v, input bit down);
    return down ? (v < 11) : (v > 9988);
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model.
  int m_d;
  bit m_run, m_wrap, m_err, m_down;
  always_comb begin
    m_down = 1'b0;
`ifdef BCD_MULT11_GEN_DOWN_EN
    m_down = dir;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d <= bcd2int(START); m_run <= 1'b0; m_wrap <= 1'b0; m_err <= 1'b0;
    end else begin
      m_wrap <= 1'b0;
      m_err  <= 1'b0;
      if (!m_run) begin
        if (load) begin
          if (is_bcd(load_val)) m_d <= bcd2int(load_val);
          else                  m_err <= 1'b1;
        end else if (en) m_run <= 1'b1;
      end else if (ready) begin
        m_d    <= next_val(m_d, m_down);
        m_wrap <= next_wraps(m_d, m_down);
        if (!en) m_run <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_D", D, int2bcd(m_d));
      chk("model_valid", {15'b0, valid}, {15'b0, m_run});
      chk("model_wrap", {15'b0, wrap}, {15'b0, m_wrap});
      chk("model_err", {15'b0, err}, {15'b0, m_err});
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    #3;
    chk("rst_D", D, START);
    chk("rst_valid", {15'b0, valid}, 16'h0);
    chk("rst_wrap", {15'b0, wrap}, 16'h0);
    chk("rst_err", {15'b0, err}, 16'h0);
    tick; rst_n = 1'b1;

    // Count from reset with ready held.
    en = 1'b1; ready = 1'b1;
    tick; chk("t1_valid", {15'b0, valid}, 16'h1); chk("t1_D0", D, 16'h0000);
    tick; chk("t1_D1", D, 16'h0011);
    tick; tick; tick; chk("t1_D4", D, 16'h0044);
    tick; tick; tick; chk("t2_D77", D, 16'h0077);

    // Stalls hold the word.
    ready = 1'b0;
    tick; tick; chk("t2_hold", D, 16'h0077); chk("t2_vhold", {15'b0, valid}, 16'h1);
    ready = 1'b1;
    tick; chk("t2_D88", D, 16'h0088);
    tick; chk("t2_D99", D, 16'h0099);
    en = 1'b0;
    tick; chk("t2_idle", {15'b0, valid}, 16'h0); chk("t2_D110", D, 16'h0110);

    // Wrap at the top.
    load = 1'b1; load_val = 16'h9988;
    tick; load = 1'b0; en = 1'b1;
    tick; chk("t3_D9988", D, 16'h9988);
    tick; chk("t3_D9999", D, 16'h9999);
    tick; chk("t3_D0000", D, 16'h0000); chk("t3_wrap", {15'b0, wrap}, 16'h1);
    tick; chk("t3_D0011", D, 16'h0011); chk("t3_nowrap", {15'b0, wrap}, 16'h0);
    en = 1'b0;
    tick;

    // Rejected and accepted seeds.
    load = 1'b1; load_val = 16'h1A23;
    tick; chk("t4_err", {15'b0, err}, 16'h1); chk("t4_Dkeep", D, 16'h0022);
    load_val = 16'h0909;
    tick; chk("t4_noerr", {15'b0, err}, 16'h0); chk("t4_D0909", D, 16'h0909);
    load = 1'b0; en = 1'b1;
    tick; tick; chk("t4_D0920", D, 16'h0920);

    // en dropped during a stall: word still delivered once.
    ready = 1'b0; en = 1'b0;
    tick; tick; tick; chk("t5_vhold", {15'b0, valid}, 16'h1);
    ready = 1'b1;
    tick; chk("t5_vdrop", {15'b0, valid}, 16'h0); chk("t5_D0931", D, 16'h0931);

    // Asynchronous reset mid-run.
    en = 1'b1;
    tick; tick;
    #2 rst_n = 1'b0;
    #1 chk("t6_rstD", D, START); chk("t6_rstv", {15'b0, valid}, 16'h0);
    tick; rst_n = 1'b1; en = 1'b0;

    // Non-multiple seed steps by 11.
    load = 1'b1; load_val = 16'h0005;
    tick; load = 1'b0; en = 1'b1;
    tick; tick; tick; chk("t7_D0027", D, 16'h0027);
    en = 1'b0; tick;

`ifdef BCD_MULT11_GEN_DOWN_EN
    load = 1'b1; load_val = 16'h0022; dir = 1'b1;
    tick; load = 1'b0; en = 1'b1;
    tick; chk("t8_D0022", D, 16'h0022);
    tick; chk("t8_D0011", D, 16'h0011);
    tick; chk("t8_D0000", D, 16'h0000);
    tick; chk("t8_D9999", D, 16'h9999); chk("t8_wrap", {15'b0, wrap}, 16'h1);
    tick; chk("t8_D9988", D, 16'h9988);
    en = 1'b0; tick; dir = 1'b0;
`endif

    tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_mult11_gen.md
# bcd_mult11_gen

- Sequential 4-digit BCD source. Emits successive multiples of 11 (0000, 0011, 0022, … 9999, wrap) on a valid/ready stream.
- Production end of the BCD divisibility-by-11 path: its `D` output feeds the combinational `BCD_divisible_by_11` checker's 16-bit `D` input.
- Stepping uses a decimal (BCD) adder, never binary arithmetic.

## Interface

Parameters:
- `START`, default 16'h0000: BCD value loaded into `D` on reset. Must be valid BCD, i.e. every nibble ≤ 9.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: request generation.
- `load`, input, 1: load `load_val` (honoured in IDLE only).
- `load_val`, input, 16: 4-digit BCD seed.
- `ready`, input, 1: consumer accepts `D` this cycle.
- `D`, output, 16: current BCD word (registered).
- `valid`, output, 1: `D` is offered.
- `wrap`, output, 1: one-cycle pulse on decimal overflow/underflow.
- `err`, output, 1: one-cycle pulse when a `load_val` is rejected.

## Operation

- FSM has two states, IDLE and RUN. Reset state is IDLE.
- IDLE (`valid`=0):
  - `load`=1 and every nibble of `load_val` ≤ 9: `D` <= `load_val`.
  - `load`=1 and any nibble > 9: `D` unchanged, `err` pulses.
  - `load`=1 has priority over `en` and keeps the FSM in IDLE that cycle.
  - Otherwise, `en`=1 moves the FSM to RUN.
- RUN (`valid`=1):
  - Handshake occurs when `valid`&&`ready`. On a handshake, `D` <= `D` + 0011 (BCD).
  - Without a handshake, `D` and `valid` hold. Valid is never withdrawn before acceptance.
  - `en`=0 takes effect only at a handshake edge; the FSM then moves to IDLE.
  - `load` is ignored in RUN. No `err` is raised.
- BCD add:
  - Per-digit add with decimal carry: digit sum > 9 gives sum−10 and carry 1.
  - A carry out of the thousands digit sets `D` <= 0000 (not the truncated sum) and pulses `wrap`.
  - Example: 9999 → 0000 with `wrap`. 9990 → 0000 with `wrap`.
- A non-multiple seed (e.g. 0005) still steps by 11: 0005, 0016, 0027, … The generator does not check divisibility.

## Timing

- Reset values (asynchronous, immediate): `D`=`START`, `valid`=0, `wrap`=0, `err`=0, FSM=IDLE.
- `en` sampled high in IDLE at edge n: `valid`=1 after edge n. Latency is 1 cycle.
- Handshake at edge m: the new `D` is visible after edge m.
  - If `en` is still 1, `valid` stays 1.
  - Throughput is one word per cycle with `ready` held high.
- `wrap` and `err` are high for exactly the cycle following the causing edge.
- A load at edge n makes the new `D` visible after edge n. `en` at edge n+1 then starts from the loaded value.
- `rst_n` low mid-stream: all outputs return to reset values immediately. An outstanding word is dropped, not re-offered.

## Configuration

- Macro: `BCD_MULT11_GEN_DOWN_EN`.
- Defined:
  - Adds input `dir` (1 bit). `dir`=1 makes each handshake subtract 0011 in BCD: digit borrow gives digit+10.
  - A borrow out of the thousands digit sets `D` <= 9999 and pulses `wrap`. Examples: 0000 → 9999, 0005 → 9999.
  - `dir` is sampled at the handshake edge. `dir`=0 behaves as the undefined build.
- Undefined: no `dir` port; the block counts up only.

## Test plan

- Reset then `en`=1, `ready`=1 for 5 cycles → `D` sequence 0000, 0011, 0022, 0033, 0044. `valid` rises 1 cycle after `en`.
- `ready` toggled 1,0,0,1 from `D`=0077 → `D` holds 0077 through the stalls, then steps to 0088, then 0099. `valid` never drops.
- Load 9988, run with `ready`=1 → 9988, 9999, 0000 with a `wrap` pulse on the 9999→0000 transition, then 0011.
- In IDLE, `load_val`=16'h1A23 → `err` pulse, `D` unchanged. Then `load_val`=16'h0909 → `D`=0909 with no `err`. Then run → 0920.
- `en` dropped while `valid`=1, `ready`=0; `ready` raised 3 cycles later → word accepted, `valid`=0 the next cycle. `rst_n` pulsed mid-RUN → `D`=`START`, `valid`=0 immediately.
- With `BCD_MULT11_GEN_DOWN_EN`, load 0022, `dir`=1, run → 0022, 0011, 0000, 9999 with `wrap`, then 9988.
